codeword_framer: RTL and testbench
==================================

# codeword_framer

Transmit-side frame assembler for the convolutional encoder/Viterbi decoder datapath. Accepts one encoder codeword per cycle, 2 bits at rate 1/2 or 3 bits at rate 1/3. Packs codewords LSB-first into fixed-length frames and hands each frame to the decoder's frame input over a valid/ready handshake. Double-buffered, so symbol intake continues while a finished frame waits for the consumer.

## Interface
- FRAME_BITS, 96, frame width in bits. Must be divisible by 6, so frames hold a whole number of symbols at both rates.
- CNT_W, $clog2(FRAME_BITS+1), width of the fill counter.
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- i_code_rate  input  1  0 = rate 1/2 (W=2), 1 = rate 1/3 (W=3).
- i_sym_valid  input  1  codeword present on i_sym.
- i_sym  input  3  codeword. Bit 0 is transmitted first; bit 2 is ignored when W=2.
- o_sym_ready  output  1  framer accepts i_sym this cycle.
- i_flush  input  1  single-cycle pulse: close the partial frame.
- o_frame  output  FRAME_BITS  assembled frame.
- o_frame_valid  output  1  o_frame holds a frame.
- o_frame_rate  output  1  code rate the o_frame frame was built with.
- i_frame_ready  input  1  consumer takes the frame when it is high together with o_frame_valid.
- o_fill  output  CNT_W  bits currently in the assembly register.

## Operation
- Symbol accept = i_sym_valid & o_sym_ready. On accept, the W bits are written to asm[fill +: W] and fill += W.
- Rate latch: i_code_rate is sampled on the first symbol of each frame (fill==0). Changes mid-frame are ignored until the next frame starts.
- Assembly FSM has three states: EMPTY, FILLING, PENDING.
  - EMPTY -> FILLING on the first accept.
  - FILLING -> transfer when fill reaches FRAME_BITS, or when i_flush is seen with fill>0.
  - A transfer copies asm (unfilled bits zero), fill and rate into the output slot, then clears asm and returns to EMPTY.
  - If the output slot is occupied and not freed in the same cycle, go to PENDING instead of transferring.
  - PENDING -> EMPTY when the output slot frees; the transfer happens that cycle.
- o_sym_ready = (state != PENDING). This is combinational from state.
- Output slot:
  - Freed by o_frame_valid & i_frame_ready.
  - Loaded by a transfer.
  - A load and a free in the same cycle are legal: the new frame replaces the old and o_frame_valid stays 1.
- Flush:
  - With fill==0 and no accept in the same cycle, flush is a no-op and no frame is emitted.
  - Flush in the same cycle as an accept: the symbol is included first, then the frame closes.
  - Flush while PENDING is held and acts when the pending frame transfers (frame is already closed).
- Zero padding: bits [FRAME_BITS-1:fill] are 0 in every emitted frame.
- Rate 1/2 frame = FRAME_BITS/2 symbols; rate 1/3 frame = FRAME_BITS/3 symbols.

## Timing
- Reset values: o_frame=0, o_frame_valid=0, o_frame_rate=0, o_fill=0, state=EMPTY, o_sym_ready=1 (combinational once rst deasserts).
- Latency:
  - Final symbol accepted in cycle t -> o_frame_valid=1 in cycle t+1 when the slot is free or freed at t.
  - Otherwise o_frame_valid=1 one cycle after the slot frees.
- Throughput: one symbol per cycle sustained, with zero bubbles, while the consumer holds i_frame_ready=1.
- o_frame and o_frame_rate are stable while o_frame_valid=1 and i_frame_ready=0.
- Reset mid-operation: the partial frame, the pending frame and the output frame are all discarded immediately (asynchronous).

## Configuration
- CODEWORD_FRAMER_ERR_INJECT_EN defined:
  - Adds input ports i_err_en (1 bit) and i_err_pos (CNT_W bits).
  - On a transfer with i_err_en=1, bit i_err_pos of the frame is inverted, provided i_err_pos < frame fill; otherwise nothing is inverted.
  - Used to exercise decoder error correction.
- Not defined: the ports are absent and frames pass through unmodified.

## Test plan
- Rate 1/2 at FRAME_BITS=96:
  - Stimulus: 48 symbols of 2'b01, i_frame_ready=1.
  - Required: one frame 0x5555…55 (96 bits) at the cycle after symbol 48, o_frame_rate=0, o_fill back to 0.
- Rate 1/3:
  - Stimulus: 32 symbols of 3'b111.
  - Required: frame all ones, o_frame_rate=1.
  - Also: toggling i_code_rate at symbol 10 has no effect on this frame.
- Backpressure:
  - Stimulus: i_frame_ready=0; send 96 rate-1/2 symbols back-to-back.
  - Required: first frame held stable; o_sym_ready falls right after symbol 96; frame 2 transfers in the cycle i_frame_ready rises; no symbol lost.
- Flush partial:
  - Stimulus: 5 rate-1/3 symbols of 3'b101, then i_flush.
  - Required: frame bits [14:0]=15'b101101101101101, remaining bits 0.
  - Also: a second flush with fill==0 emits nothing.
- Reset mid-frame:
  - Stimulus: assert rst after 20 symbols while a frame is pending.
  - Required: all outputs at reset values within the same cycle, o_sym_ready=1 after release.
- Error injection (macro defined):
  - Stimulus: i_err_en=1, i_err_pos=7, all-zero rate-1/2 frame.
  - Required: o_frame=1<<7.
  - Also: i_err_pos=20 on a flushed 16-bit frame leaves the frame unchanged.

Source files
------------

// File: rtl/codeword_framer_if.sv
// codeword_framer_if
//   Bundles the symbol intake, flush and frame output signals of the
//   codeword_framer.
//   master modport : the environment side. It drives symbols, rate, flush and
//                    frame_ready, and it observes ready, frame and fill.
//   slave modport  : the framer side.
// Parameters: FRAME_BITS sets the frame width. CNT_W sets the fill counter width.
interface codeword_framer_if #(
  parameter int FRAME_BITS = 96,
  parameter int CNT_W      = $clog2(FRAME_BITS + 1)
);
  logic                  i_code_rate;
  logic                  i_sym_valid;
  logic [2:0]            i_sym;
  logic                  o_sym_ready;
  logic                  i_flush;
  logic [FRAME_BITS-1:0] o_frame;
  logic                  o_frame_valid;
  logic                  o_frame_rate;
  logic                  i_frame_ready;
  logic [CNT_W-1:0]      o_fill;

  modport master (
    output i_code_rate, i_sym_valid, i_sym, i_flush, i_frame_ready,
    input  o_sym_ready, o_frame, o_frame_valid, o_frame_rate, o_fill
  );

  modport slave (
    input  i_code_rate, i_sym_valid, i_sym, i_flush, i_frame_ready,
    output o_sym_ready, o_frame, o_frame_valid, o_frame_rate, o_fill
  );
endinterface

// File: rtl/codeword_framer.sv
// codeword_framer
//   Transmit-side frame assembler. It accepts one codeword per cycle:
//   2 bits at rate 1/2, or 3 bits at rate 1/3. Codewords are packed LSB-first
//   into FRAME_BITS-wide frames. Each finished frame is handed out over a
//   valid/ready handshake. An assembly register and a separate output slot
//   form a double buffer, so intake continues while a finished frame waits.
// Ports:
//   clk, rst : clock, and an asynchronous active-high reset
//   bus      : codeword_framer_if.slave. It carries the symbol intake, the
//              flush pulse, the frame output and the fill level.
//   i_err_en, i_err_pos : present only when CODEWORD_FRAMER_ERR_INJECT_EN is
//              defined. They invert one bit of a frame as it is transferred.
// Optional feature macro: CODEWORD_FRAMER_ERR_INJECT_EN
module codeword_framer #(
  parameter int FRAME_BITS = 96,
  parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  codeword_framer_if.slave     bus
`ifdef CODEWORD_FRAMER_ERR_INJECT_EN
  ,
  input  logic                 i_err_en,
  input  logic [CNT_W-1:0]     i_err_pos
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t                state_r;
  logic [FRAME_BITS-1:0] asm_r;
  logic [CNT_W-1:0]      fill_r;
  logic                  rate_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic                  frame_valid_r;
  logic                  frame_rate_r;

  logic                  accept_s;
  logic                  cur_rate_s;
  logic [2:0]            sym_bits_s;
  logic [CNT_W-1:0]      sym_w_s;
  logic [FRAME_BITS-1:0] asm_next_s;
  logic [CNT_W-1:0]      fill_next_s;
  logic                  rate_next_s;
  logic                  close_s;
  logic                  slot_free_s;
  logic                  xfer_s;
  logic [FRAME_BITS-1:0] src_asm_s;
  logic                  src_rate_s;
  logic [FRAME_BITS-1:0] err_mask_s;
  logic [FRAME_BITS-1:0] frame_in_s;

  assign accept_s   = bus.i_sym_valid & (state_r != ST_PENDING);
  // The rate of a new frame comes from i_code_rate when its first symbol
  // arrives. After that the latched rate governs the frame.
  assign cur_rate_s = (fill_r == {CNT_W{1'b0}}) ? bus.i_code_rate : rate_r;
  assign sym_bits_s = {cur_rate_s & bus.i_sym[2], bus.i_sym[1:0]};
  assign sym_w_s    = cur_rate_s ? CNT_W'(3) : CNT_W'(2);
  // The slot can take a frame if it is empty or is being emptied this cycle.
  assign slot_free_s = ~frame_valid_r | bus.i_frame_ready;

  // Next assembly contents, fill level and latched rate after a possible accept.
  always_comb begin
    asm_next_s  = asm_r;
    fill_next_s = fill_r;
    rate_next_s = rate_r;
    if (accept_s) begin
      // Unfilled bits are always zero, so an OR places the codeword.
      asm_next_s  = asm_r | ({{(FRAME_BITS-3){1'b0}}, sym_bits_s} << fill_r);
      fill_next_s = fill_r + sym_w_s;
      rate_next_s = cur_rate_s;
    end else begin
      asm_next_s  = asm_r;
    end
  end

  // Frame close and transfer decision, and selection of the frame source.
  always_comb begin
    close_s    = 1'b0;
    xfer_s     = 1'b0;
    src_asm_s  = asm_next_s;
    src_rate_s = rate_next_s;
    if (state_r == ST_PENDING) begin
      // This frame is already closed. A flush seen here has nothing left to close.
      src_asm_s  = asm_r;
      src_rate_s = rate_r;
      xfer_s     = slot_free_s;
    end else begin
      close_s = (fill_next_s == CNT_W'(FRAME_BITS)) |
                (bus.i_flush & (fill_next_s != {CNT_W{1'b0}}));
      xfer_s  = close_s & slot_free_s;
    end
  end

`ifdef CODEWORD_FRAMER_ERR_INJECT_EN
  logic [CNT_W-1:0] src_fill_s;
  assign src_fill_s = (state_r == ST_PENDING) ? fill_r : fill_next_s;

  // Single-bit error mask. Only positions inside the filled part of the frame qualify.
  always_comb begin
    err_mask_s = {FRAME_BITS{1'b0}};
    if (i_err_en && (i_err_pos < src_fill_s)) begin
      err_mask_s = {{(FRAME_BITS-1){1'b0}}, 1'b1} << i_err_pos;
    end else begin
      err_mask_s = {FRAME_BITS{1'b0}};
    end
  end
`else
  assign err_mask_s = {FRAME_BITS{1'b0}};
`endif

  assign frame_in_s = src_asm_s ^ err_mask_s;

  // Assembly FSM and output slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_EMPTY;
      asm_r         <= {FRAME_BITS{1'b0}};
      fill_r        <= {CNT_W{1'b0}};
      rate_r        <= 1'b0;
      frame_r       <= {FRAME_BITS{1'b0}};
      frame_valid_r <= 1'b0;
      frame_rate_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY, ST_FILLING: begin
          if (close_s && slot_free_s) begin
            asm_r   <= {FRAME_BITS{1'b0}};
            fill_r  <= {CNT_W{1'b0}};
            state_r <= ST_EMPTY;
          end else if (close_s) begin
            // The slot is busy, so the closed frame stays in the assembly register.
            asm_r   <= asm_next_s;
            fill_r  <= fill_next_s;
            rate_r  <= rate_next_s;
            state_r <= ST_PENDING;
          end else begin
            asm_r   <= asm_next_s;
            fill_r  <= fill_next_s;
            rate_r  <= rate_next_s;
            state_r <= (fill_next_s != {CNT_W{1'b0}}) ? ST_FILLING : ST_EMPTY;
          end
        end
        ST_PENDING: begin
          if (slot_free_s) begin
            asm_r   <= {FRAME_BITS{1'b0}};
            fill_r  <= {CNT_W{1'b0}};
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_PENDING;
          end
        end
        default: begin
          asm_r   <= {FRAME_BITS{1'b0}};
          fill_r  <= {CNT_W{1'b0}};
          state_r <= ST_EMPTY;
        end
      endcase

      // A load wins over a free in the same cycle, so valid stays high.
      if (xfer_s) begin
        frame_r       <= frame_in_s;
        frame_valid_r <= 1'b1;
        frame_rate_r  <= src_rate_s;
      end else if (frame_valid_r && bus.i_frame_ready) begin
        frame_valid_r <= 1'b0;
      end else begin
        frame_valid_r <= frame_valid_r;
      end
    end
  end

  assign bus.o_sym_ready   = (state_r != ST_PENDING);
  assign bus.o_frame       = frame_r;
  assign bus.o_frame_valid = frame_valid_r;
  assign bus.o_frame_rate  = frame_rate_r;
  assign bus.o_fill        = fill_r;

endmodule

// File: tb/tb_codeword_framer.sv
// tb_codeword_framer
//   Directed bench for codeword_framer at FRAME_BITS=96. The clock period is
//   10. Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_codeword_framer;
  localparam int FRAME_BITS = 96;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  codeword_framer_if #(.FRAME_BITS(FRAME_BITS)) bus ();

`ifdef CODEWORD_FRAMER_ERR_INJECT_EN
  logic             err_en;
  logic [CNT_W-1:0] err_pos;
`endif

  codeword_framer #(.FRAME_BITS(FRAME_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef CODEWORD_FRAMER_ERR_INJECT_EN
    ,
    .i_err_en  (err_en),
    .i_err_pos (err_pos)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present n back-to-back symbols of value s.
  task automatic send(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_sym       = s;
      bus.i_sym_valid = 1'b1;
      tick();
    end
    bus.i_sym_valid = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_code_rate   = 1'b0;
    bus.i_sym_valid   = 1'b0;
    bus.i_sym         = 3'b000;
    bus.i_flush       = 1'b0;
    bus.i_frame_ready = 1'b1;
`ifdef CODEWORD_FRAMER_ERR_INJECT_EN
    err_en  = 1'b0;
    err_pos = '0;
`endif
    tick(); tick(); tick();
    chk("rst_frame", bus.o_frame, 128'd0);
    chk("rst_valid", bus.o_frame_valid, 128'd0);
    chk("rst_rate", bus.o_frame_rate, 128'd0);
    chk("rst_fill", bus.o_fill, 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", bus.o_sym_ready, 128'd1);

    // Rate 1/2 test: 48 symbols of 01. Bit 2 is set to confirm that it is ignored.
    bus.i_code_rate = 1'b0;
    send(3'b101, 47);
    chk("r2_fill47", bus.o_fill, 128'd94);
    chk("r2_novalid", bus.o_frame_valid, 128'd0);
    send(3'b101, 1);
    chk("r2_valid", bus.o_frame_valid, 128'd1);
    chk("r2_frame", bus.o_frame, 128'h5555_5555_5555_5555_5555_5555);
    chk("r2_rate", bus.o_frame_rate, 128'd0);
    chk("r2_fill0", bus.o_fill, 128'd0);
    tick();
    chk("r2_taken", bus.o_frame_valid, 128'd0);

    // Rate 1/3 test: 32 symbols of 111. The rate input toggles after symbol 10.
    bus.i_code_rate = 1'b1;
    send(3'b111, 10);
    chk("r3_fill10", bus.o_fill, 128'd30);
    bus.i_code_rate = 1'b0;
    send(3'b111, 22);
    chk("r3_valid", bus.o_frame_valid, 128'd1);
    chk("r3_frame", bus.o_frame, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("r3_rate", bus.o_frame_rate, 128'd1);
    chk("r3_fill0", bus.o_fill, 128'd0);
    tick();
    chk("r3_taken", bus.o_frame_valid, 128'd0);

    // Backpressure test.
    // Frame 1 alternates symbols 10,00, giving 0x2222... .
    // Frame 2 alternates symbols 11,01, giving 0x7777... .
    bus.i_frame_ready = 1'b0;
    bus.i_code_rate   = 1'b0;
    for (int i = 0; i < 96; i++) begin
      if (i < 48) bus.i_sym = (i % 2 == 0) ? 3'b010 : 3'b000;
      else        bus.i_sym = (i % 2 == 0) ? 3'b011 : 3'b001;
      bus.i_sym_valid = 1'b1;
      if (i == 95) chk("bp_ready_last", bus.o_sym_ready, 128'd1);
      tick();
      if (i == 47) begin
        chk("bp_f1_valid", bus.o_frame_valid, 128'd1);
        chk("bp_f1_frame", bus.o_frame, 128'h2222_2222_2222_2222_2222_2222);
      end
      if (i == 71) chk("bp_f1_hold", bus.o_frame, 128'h2222_2222_2222_2222_2222_2222);
    end
    bus.i_sym_valid = 1'b0;
    chk("bp_ready_low", bus.o_sym_ready, 128'd0);
    chk("bp_fill_full", bus.o_fill, 128'd96);
    tick(); tick();
    chk("bp_f1_stable", bus.o_frame, 128'h2222_2222_2222_2222_2222_2222);
    chk("bp_f1_vstable", bus.o_frame_valid, 128'd1);
    bus.i_frame_ready = 1'b1;
    tick();
    chk("bp_f2_frame", bus.o_frame, 128'h7777_7777_7777_7777_7777_7777);
    chk("bp_f2_valid", bus.o_frame_valid, 128'd1);
    chk("bp_ready_back", bus.o_sym_ready, 128'd1);
    chk("bp_fill0", bus.o_fill, 128'd0);
    tick();
    chk("bp_taken", bus.o_frame_valid, 128'd0);

    // Flush test: a partial frame of 5 rate-1/3 symbols of 101.
    bus.i_code_rate = 1'b1;
    send(3'b101, 5);
    chk("fl_fill15", bus.o_fill, 128'd15);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("fl_valid", bus.o_frame_valid, 128'd1);
    chk("fl_frame", bus.o_frame, 128'h5B6D);
    chk("fl_rate", bus.o_frame_rate, 128'd1);
    chk("fl_fill0", bus.o_fill, 128'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("fl_empty_a", bus.o_frame_valid, 128'd0);
    tick();
    chk("fl_empty_b", bus.o_frame_valid, 128'd0);

    // Flush in the same cycle as a symbol: the symbol is included in the frame.
    bus.i_code_rate = 1'b0;
    bus.i_sym       = 3'b011;
    bus.i_sym_valid = 1'b1;
    bus.i_flush     = 1'b1;
    tick();
    bus.i_sym_valid = 1'b0;
    bus.i_flush     = 1'b0;
    chk("fa_frame", bus.o_frame, 128'h3);
    chk("fa_valid", bus.o_frame_valid, 128'd1);
    chk("fa_rate", bus.o_frame_rate, 128'd0);
    chk("fa_fill0", bus.o_fill, 128'd0);
    tick();

    // Reset mid-frame: one frame waits in the output slot and 20 symbols are in assembly.
    bus.i_frame_ready = 1'b0;
    send(3'b001, 48);
    send(3'b010, 20);
    chk("rm_fill40", bus.o_fill, 128'd40);
    chk("rm_valid_pre", bus.o_frame_valid, 128'd1);
    rst = 1'b1;
    #1;
    chk("rm_frame", bus.o_frame, 128'd0);
    chk("rm_valid", bus.o_frame_valid, 128'd0);
    chk("rm_rate", bus.o_frame_rate, 128'd0);
    chk("rm_fill", bus.o_fill, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_ready", bus.o_sym_ready, 128'd1);
    bus.i_frame_ready = 1'b1;
    tick();

`ifdef CODEWORD_FRAMER_ERR_INJECT_EN
    // Error injection: bit 7 of an all-zero frame is inverted.
    err_en  = 1'b1;
    err_pos = CNT_W'(7);
    bus.i_code_rate = 1'b0;
    send(3'b000, 48);
    chk("ei_frame", bus.o_frame, 128'h80);
    tick();
    // Position 20 lies beyond the 16 filled bits, so the frame is unchanged.
    err_pos = CNT_W'(20);
    send(3'b001, 8);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("ei_oob_frame", bus.o_frame, 128'h5555);
    chk("ei_oob_valid", bus.o_frame_valid, 128'd1);
    err_en = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
